// File: rtl/ov7670_cfg_sequencer.sv
// Walks an OV7670 configuration ROM and turns each entry into an I2C register write,
// a millisecond delay, or the end of the pass, retrying writes that the camera NACKs.
module ov7670_cfg_sequencer #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h21,
    parameter int         TICKS_PER_MS = 100000,
    parameter int         MAX_RETRY    = 3,
    parameter int         ROM_AW       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_wr,
    output logic [6:0]        o_slave_addr,
    output logic [7:0]        o_reg_addr,
    output logic [7:0]        o_wdata,
    input  logic              i_busy,
    input  logic              i_nack_slave,
    input  logic              i_nack_addr,
    input  logic              i_nack_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, FETCH, DECODE, ISSUE, WAIT_ACC,
        WAIT_END, CHECK, DELAY, DONE, ERROR
    } stateT;

    localparam logic [ROM_AW-1:0] LAST_INDEX  = '1;
    localparam logic [31:0]       TICKS       = 32'(TICKS_PER_MS);
    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRY);

    stateT             r_state,     w_stateNext;
    logic [ROM_AW-1:0] r_index,     w_indexNext;
    logic [7:0]        r_retry,     w_retryNext;
    logic [31:0]       r_delay,     w_delayNext;
    logic              r_nack,      w_nackNext;
    logic              r_wr,        w_wrNext;
    logic              r_busy,      w_busyNext;
    logic              r_done,      w_doneNext;
    logic              r_error,     w_errorNext;
    logic [7:0]        r_regAddr,   w_regAddrNext;
    logic [7:0]        r_wdata,     w_wdataNext;
    logic [6:0]        r_slaveAddr;

    logic        w_nackAny;
    logic        w_atLast;
    logic [31:0] w_delayLoad;

    assign w_nackAny   = i_nack_slave | i_nack_addr | i_nack_data;
    assign w_atLast    = (r_index == LAST_INDEX);
    assign w_delayLoad = {24'd0, i_rom_data[7:0]} * TICKS;

    // The last ROM slot ends the pass after it is processed, so the index never wraps.
    always_comb begin
        w_stateNext   = r_state;
        w_indexNext   = r_index;
        w_retryNext   = r_retry;
        w_delayNext   = r_delay;
        w_nackNext    = r_nack;
        w_wrNext      = 1'b0;
        w_busyNext    = r_busy;
        w_doneNext    = r_done;
        w_errorNext   = r_error;
        w_regAddrNext = r_regAddr;
        w_wdataNext   = r_wdata;

        case (r_state)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    w_stateNext = WAIT_RDY;
                    w_indexNext = '0;
                    w_retryNext = '0;
                    w_doneNext  = 1'b0;
                    w_errorNext = 1'b0;
                    w_busyNext  = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (!i_busy) begin
                    w_stateNext = FETCH;
                end
            end
            FETCH: begin
                w_stateNext = DECODE;
            end
            DECODE: begin
                if (i_rom_data == 16'hFFFF) begin
                    w_stateNext = DONE;
                    w_busyNext  = 1'b0;
                    w_doneNext  = 1'b1;
                end else if (i_rom_data[15:8] == 8'hF0) begin
                    w_stateNext = DELAY;
                    w_delayNext = w_delayLoad;
                end else begin
                    w_stateNext   = ISSUE;
                    w_regAddrNext = i_rom_data[15:8];
                    w_wdataNext   = i_rom_data[7:0];
                    w_nackNext    = 1'b0;
                    w_wrNext      = 1'b1;
                end
            end
            ISSUE: begin
                if (i_busy) begin
                    w_stateNext = WAIT_ACC;
                    w_nackNext  = r_nack | w_nackAny;
                end else begin
                    w_wrNext = 1'b1;
                end
            end
            // The master clears its NACK flags when busy falls, so they are captured while busy.
            WAIT_ACC, WAIT_END: begin
                if (i_busy) begin
                    w_stateNext = WAIT_END;
                    w_nackNext  = r_nack | w_nackAny;
                end else begin
                    w_stateNext = CHECK;
                end
            end
            CHECK: begin
                if (!r_nack) begin
                    w_retryNext = '0;
                    if (w_atLast) begin
                        w_stateNext = DONE;
                        w_busyNext  = 1'b0;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stateNext = FETCH;
                        w_indexNext = r_index + 1'b1;
                    end
                end else if (r_retry < RETRY_LIMIT) begin
                    w_retryNext = r_retry + 8'd1;
                    w_stateNext = ISSUE;
                    w_nackNext  = 1'b0;
                    w_wrNext    = 1'b1;
                end else begin
                    w_stateNext = ERROR;
                    w_busyNext  = 1'b0;
                    w_errorNext = 1'b1;
                end
            end
            DELAY: begin
                if (r_delay == '0) begin
                    if (w_atLast) begin
                        w_stateNext = DONE;
                        w_busyNext  = 1'b0;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stateNext = FETCH;
                        w_indexNext = r_index + 1'b1;
                    end
                end else begin
                    w_delayNext = r_delay - 32'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_retry     <= '0;
            r_delay     <= '0;
            r_nack      <= 1'b0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_regAddr   <= '0;
            r_wdata     <= '0;
            r_slaveAddr <= SLAVE_ADDR;
        end else begin
            r_state     <= w_stateNext;
            r_index     <= w_indexNext;
            r_retry     <= w_retryNext;
            r_delay     <= w_delayNext;
            r_nack      <= w_nackNext;
            r_wr        <= w_wrNext;
            r_busy      <= w_busyNext;
            r_done      <= w_doneNext;
            r_error     <= w_errorNext;
            r_regAddr   <= w_regAddrNext;
            r_wdata     <= w_wdataNext;
            r_slaveAddr <= SLAVE_ADDR;
        end
    end

    assign o_rom_addr   = r_index;
    assign o_wr         = r_wr;
    assign o_slave_addr = r_slaveAddr;
    assign o_reg_addr   = r_regAddr;
    assign o_wdata      = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench: a ROM and a behavioural I2C master surround the sequencer, and every
// write the master accepts is popped against the writes each configuration table should yield.
`timescale 1ns/1ps
module tb_ov7670_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic        o_wr;
    logic [6:0]  o_slave_addr;
    logic [7:0]  o_reg_addr;
    logic [7:0]  o_wdata;
    logic        i_busy;
    logic        i_nack_slave;
    logic        i_nack_addr;
    logic        i_nack_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    logic [15:0] romMem [0:15];
    logic [15:0] romQ;
    logic [15:0] expQ [$];

    int   errCount = 0;
    int   checkCount = 0;
    int   cycleCnt = 0;
    int   writeCount = 0;
    int   startCyc = 0;
    int   firstWrCyc = -1;
    int   nackRemain = 0;
    int   nackKind = 0;
    logic [7:0] nackReg = 8'hFF;
    logic holdBusy = 1'b1;
    logic wrDuringHold = 1'b0;
    logic mActive = 1'b0;
    int   mCnt = 0;

    ov7670_cfg_sequencer #(
        .SLAVE_ADDR  (7'h21),
        .TICKS_PER_MS(10),
        .MAX_RETRY   (3),
        .ROM_AW      (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (i_start),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_wr        (o_wr),
        .o_slave_addr(o_slave_addr),
        .o_reg_addr  (o_reg_addr),
        .o_wdata     (o_wdata),
        .i_busy      (i_busy),
        .i_nack_slave(i_nack_slave),
        .i_nack_addr (i_nack_addr),
        .i_nack_data (i_nack_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) romQ <= romMem[o_rom_addr];
    assign i_rom_data = romQ;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // I2C master model: accepts o_wr, stays busy four cycles, reports NACKs while busy.
    initial begin
        logic [15:0] expWord;
        i_busy       = 1'b1;
        i_nack_slave = 1'b0;
        i_nack_addr  = 1'b0;
        i_nack_data  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mActive = 1'b0;
                mCnt = 0;
                {i_nack_slave, i_nack_addr, i_nack_data} = 3'b000;
            end else if (mActive) begin
                mCnt++;
                if (mCnt >= 4) begin
                    mActive = 1'b0;
                    {i_nack_slave, i_nack_addr, i_nack_data} = 3'b000;
                end
            end else if (o_wr) begin
                if (holdBusy) begin
                    wrDuringHold = 1'b1;
                end else begin
                    mActive = 1'b1;
                    mCnt = 0;
                    writeCount++;
                    if (firstWrCyc < 0) firstWrCyc = cycleCnt;
                    checkOutput("wrBusy", o_busy, 1);
                    checkOutput("wrSlave", o_slave_addr, 7'h21);
                    if (expQ.size() == 0) begin
                        checkOutput("wrUnexpected", expQ.size(), 1);
                    end else begin
                        expWord = expQ.pop_front();
                        checkOutput("wrField", {o_reg_addr, o_wdata}, expWord);
                    end
                    if (nackRemain > 0 && (nackReg == 8'hFF || nackReg == o_reg_addr)) begin
                        nackRemain--;
                        if (nackKind == 0) i_nack_addr = 1'b1;
                        else i_nack_data = 1'b1;
                    end
                end
            end
            i_busy = holdBusy | mActive;
        end
    end

    task automatic applyStimulus();
        firstWrCyc = -1;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        startCyc = cycleCnt;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitFinish(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (o_done || o_error) break;
        end
        checkOutput("passFinished", o_done | o_error, 1);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 16; i++) romMem[i] = 16'hFFFF;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearRom();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstWr", o_wr, 0);
        checkOutput("rstBusy", o_busy, 0);
        checkOutput("rstDone", o_done, 0);
        checkOutput("rstError", o_error, 0);
        checkOutput("rstRomAddr", o_rom_addr, 0);
        checkOutput("rstRegAddr", o_reg_addr, 0);
        checkOutput("rstWdata", o_wdata, 0);
        checkOutput("rstSlave", o_slave_addr, 7'h21);
        rst = 1'b0;

        // Master busy after its own reset: no write may go out until busy falls.
        repeat (50) @(posedge clk);
        romMem[0] = 16'h1280; romMem[1] = 16'h1204; romMem[2] = 16'hFFFF;
        expQ.push_back(16'h1280);
        expQ.push_back(16'h1204);
        writeCount = 0;
        applyStimulus();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("holdNoWr", writeCount + int'(wrDuringHold), 0);
        holdBusy = 1'b0;
        waitFinish(500);
        checkOutput("basicDone", o_done, 1);
        checkOutput("basicBusy", o_busy, 0);
        checkOutput("basicError", o_error, 0);
        checkOutput("basicWrites", writeCount, 2);
        checkOutput("basicQueue", expQ.size(), 0);

        // Delay entries: F002 is 20 cycles, F000 is zero-length.
        clearRom();
        romMem[0] = 16'hF002; romMem[1] = 16'hF000; romMem[2] = 16'h1111;
        expQ.push_back(16'h1111);
        writeCount = 0;
        applyStimulus();
        waitFinish(500);
        checkOutput("delayDone", o_done, 1);
        checkOutput("delayWrites", writeCount, 1);
        checkOutput("delayGap", (firstWrCyc - startCyc) >= 23, 1);

        // Three address NACKs then an ACK: four identical attempts.
        clearRom();
        romMem[0] = 16'h3A55;
        for (int i = 0; i < 4; i++) expQ.push_back(16'h3A55);
        nackKind = 0; nackReg = 8'hFF; nackRemain = 3;
        writeCount = 0;
        applyStimulus();
        waitFinish(500);
        checkOutput("retryDone", o_done, 1);
        checkOutput("retryError", o_error, 0);
        checkOutput("retryWrites", writeCount, 4);
        checkOutput("retryQueue", expQ.size(), 0);

        // Table with no end marker stops after the last slot.
        clearRom();
        for (int i = 0; i < 16; i++) begin
            romMem[i] = {8'h20 + 8'(i), 8'(i)};
            expQ.push_back({8'h20 + 8'(i), 8'(i)});
        end
        writeCount = 0;
        applyStimulus();
        waitFinish(2000);
        checkOutput("edgeDone", o_done, 1);
        checkOutput("edgeWrites", writeCount, 16);
        checkOutput("edgeRomAddr", o_rom_addr, 15);
        checkOutput("edgeQueue", expQ.size(), 0);

        // Data always NACKed at entry 1: four attempts, then error holding the index.
        clearRom();
        romMem[0] = 16'h1280; romMem[1] = 16'h4C77; romMem[2] = 16'hFFFF;
        expQ.push_back(16'h1280);
        for (int i = 0; i < 4; i++) expQ.push_back(16'h4C77);
        nackKind = 1; nackReg = 8'h4C; nackRemain = 1000;
        writeCount = 0;
        applyStimulus();
        waitFinish(500);
        checkOutput("errError", o_error, 1);
        checkOutput("errDone", o_done, 0);
        checkOutput("errBusy", o_busy, 0);
        checkOutput("errRomAddr", o_rom_addr, 1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("errWrites", writeCount, 5);
        checkOutput("errQueue", expQ.size(), 0);
        nackRemain = 0;

        // Reset during the second write, then a fresh pass must start at entry 0.
        clearRom();
        romMem[0] = 16'h1280; romMem[1] = 16'h1204; romMem[2] = 16'hFFFF;
        expQ.push_back(16'h1280);
        expQ.push_back(16'h1204);
        writeCount = 0;
        applyStimulus();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (writeCount == 2) break;
        end
        checkOutput("midWrSeen", writeCount, 2);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstWr", o_wr, 0);
        checkOutput("midRstBusy", o_busy, 0);
        checkOutput("midRstDone", o_done, 0);
        checkOutput("midRstError", o_error, 0);
        checkOutput("midRstRomAddr", o_rom_addr, 0);
        checkOutput("midRstRegAddr", o_reg_addr, 0);
        checkOutput("midRstWdata", o_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midNoResume", writeCount, 2);
        expQ.push_back(16'h1280);
        expQ.push_back(16'h1204);
        writeCount = 0;
        applyStimulus();
        waitFinish(500);
        checkOutput("restartDone", o_done, 1);
        checkOutput("restartWrites", writeCount, 2);
        checkOutput("restartQueue", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
